// File: rtl/pr_icap_requester.sv
// pr_icap_requester: sequences one host command into an ICAP controller.
// A configure command unpacks 64-bit source beats into 32-bit controller
// words; a readback command passes controller beats straight to the host.
// A watchdog aborts any command that stalls for too long.
module pr_icap_requester #(
  parameter int C_NUMWORDS_WIDTH = 27,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                        aclk_i,
  input  logic                        areset_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_rdwrb_i,
  input  logic [C_NUMWORDS_WIDTH-1:0] cmd_size_i,
  input  logic [63:0]                 s_axis_tdata_i,
  input  logic [7:0]                  s_axis_tkeep_i,
  input  logic                        s_axis_tvalid_i,
  output logic                        s_axis_tready_o,
  output logic                        ctrl_rdwrb_o,
  output logic [C_NUMWORDS_WIDTH-1:0] ctrl_size_o,
  output logic                        ctrl_valid_o,
  input  logic                        ctrl_ready_i,
  input  logic                        done_i,
  output logic [31:0]                 write_data_o,
  output logic                        write_valid_o,
  input  logic                        write_ready_i,
  output logic                        write_last_o,
  input  logic [63:0]                 read_data_i,
  input  logic [7:0]                  read_keep_i,
  input  logic                        read_valid_i,
  output logic                        read_ready_o,
  input  logic                        read_last_i,
  output logic [63:0]                 m_axis_tdata_o,
  output logic [7:0]                  m_axis_tkeep_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic                        m_axis_tlast_o,
  output logic                        busy_o,
  output logic [2:0]                  status_err_o,
  output logic [C_NUMWORDS_WIDTH-1:0] words_xfer_o
);

  localparam int W  = C_NUMWORDS_WIDTH;
  localparam int TW = (C_TIMEOUT_CYCLES < 2) ? 1 : $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(C_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [W-1:0]  WORD_ONE   = W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_READ      = 3'd4;

  // status bit positions: {timeout, count_mismatch, zero_size}
  localparam int ERR_ZERO     = 0;
  localparam int ERR_MISMATCH = 1;
  localparam int ERR_TIMEOUT  = 2;

  logic [2:0]    state_q, state_d;
  logic          rdwrb_q, rdwrb_d;
  logic [W-1:0]  size_q, size_d;
  logic [2:0]    status_q, status_d;
  logic [W-1:0]  words_q, words_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hi_q, hi_d;
  logic          done_seen_q, done_seen_d;
  logic          last_seen_q, last_seen_d;
  logic          ready_q;

  logic          cmd_hs, ctrl_hs, write_hs, read_hs, any_hs;
  logic          final_word, beat_end;
  logic [1:0]    read_inc;
  logic          seen_done, seen_last;
  logic          unused_keep;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {{(W - 1){1'b0}}, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  // Lower keep bits are implied by the beat always carrying its low word.
  assign unused_keep = ^s_axis_tkeep_i[3:0];

  assign cmd_ready_o  = (state_q == S_IDLE) && ready_q;
  assign busy_o       = (state_q != S_IDLE);
  assign status_err_o = status_q;
  assign words_xfer_o = words_q;

  assign ctrl_valid_o = (state_q == S_ISSUE);
  assign ctrl_rdwrb_o = rdwrb_q;
  assign ctrl_size_o  = size_q;

  assign final_word      = (words_q == (size_q - WORD_ONE));
  assign write_valid_o   = (state_q == S_WRITE) && s_axis_tvalid_i;
  assign write_data_o    = hi_q ? s_axis_tdata_i[63:32] : s_axis_tdata_i[31:0];
  assign write_last_o    = write_valid_o && final_word;
  assign beat_end        = hi_q || (s_axis_tkeep_i[7:4] != 4'hF) || final_word;
  assign write_hs        = write_valid_o && write_ready_i;
  assign s_axis_tready_o = write_hs && beat_end;

  assign read_ready_o    = (state_q == S_READ) && m_axis_tready_i;
  assign m_axis_tvalid_o = (state_q == S_READ) && read_valid_i;
  assign m_axis_tdata_o  = read_data_i;
  assign m_axis_tkeep_o  = read_keep_i;
  assign m_axis_tlast_o  = (state_q == S_READ) && read_last_i;
  assign read_hs         = m_axis_tvalid_o && m_axis_tready_i;
  assign read_inc        = (read_keep_i == 8'hFF) ? 2'd2 :
                           (read_keep_i == 8'h0F) ? 2'd1 : 2'd0;

  assign cmd_hs  = cmd_ready_o && cmd_valid_i;
  assign ctrl_hs = ctrl_valid_o && ctrl_ready_i;
  assign any_hs  = ctrl_hs || write_hs || read_hs || done_i;

  // Next-state logic for the command sequencer and its watchdog.
  always_comb begin
    state_d     = state_q;
    rdwrb_d     = rdwrb_q;
    size_d      = size_q;
    status_d    = status_q;
    words_d     = words_q;
    timer_d     = timer_q;
    hi_d        = hi_q;
    done_seen_d = done_seen_q;
    last_seen_d = last_seen_q;
    seen_done   = 1'b0;
    seen_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d     = '0;
        hi_d        = 1'b0;
        done_seen_d = 1'b0;
        last_seen_d = 1'b0;
        if (cmd_hs) begin
          rdwrb_d  = cmd_rdwrb_i;
          size_d   = cmd_size_i;
          words_d  = '0;
          status_d = '0;
          if (cmd_size_i == '0) begin
            status_d[ERR_ZERO] = 1'b1;
          end else begin
            state_d = S_ISSUE;
            timer_d = TIMER_LOAD;
          end
        end
      end
      S_ISSUE: begin
        if (ctrl_ready_i) state_d = rdwrb_q ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        if (write_hs) begin
          words_d = sat_add(words_q, 2'd1);
          hi_d    = !beat_end;
          if (final_word) begin
            hi_d    = 1'b0;
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (done_i) state_d = S_IDLE;
      end
      S_READ: begin
        seen_done = done_seen_q || done_i;
        seen_last = last_seen_q || (read_hs && read_last_i);
        if (read_hs) words_d = sat_add(words_q, read_inc);
        if (read_hs && read_last_i && (words_d != size_q)) status_d[ERR_MISMATCH] = 1'b1;
        done_seen_d = seen_done;
        last_seen_d = seen_last;
        if (seen_done && seen_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      if (any_hs) begin
        timer_d = TIMER_LOAD;
      end else if (timer_q <= TIMER_ONE) begin
        timer_d               = '0;
        status_d[ERR_TIMEOUT] = 1'b1;
        state_d               = S_IDLE;
      end else begin
        timer_d = timer_q - TIMER_ONE;
      end
    end
  end

  // State registers; reset parks everything idle with cmd_ready held low.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q     <= S_IDLE;
      rdwrb_q     <= 1'b0;
      size_q      <= '0;
      status_q    <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      hi_q        <= 1'b0;
      done_seen_q <= 1'b0;
      last_seen_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdwrb_q     <= rdwrb_d;
      size_q      <= size_d;
      status_q    <= status_d;
      words_q     <= words_d;
      timer_q     <= timer_d;
      hi_q        <= hi_d;
      done_seen_q <= done_seen_d;
      last_seen_q <= last_seen_d;
      ready_q     <= 1'b1;
    end
  end

endmodule

// File: doc/pr_icap_requester.md
PR_ICAP_REQUESTER -- requirements
Module: pr_icap_requester

Interface
REQ-001 The block SHALL have parameter C_NUMWORDS_WIDTH, default 27, giving the width of all 32-bit-word counts.
REQ-002 The block SHALL have parameter C_TIMEOUT_CYCLES, default 65535, giving the idle cycles allowed before timeout.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- cmd_valid / cmd_ready  in/out  1/1  host command handshake
- cmd_rdwrb  in  1  1=readback, 0=configure
- cmd_size  in  C_NUMWORDS_WIDTH  32-bit word count
- s_axis_tdata / tkeep / tvalid / tready  in/in/in/out  64/8/1/1  bitstream source
- ctrl_rdwrb / ctrl_size / ctrl_valid / ctrl_ready  out/out/out/in  1/C_NUMWORDS_WIDTH/1/1  command to ICAP controller
- done  in  1  controller completion pulse
- write_data / write_valid / write_ready / write_last  out/out/in/out  32/1/1/1  word stream to controller
- read_data / read_keep / read_valid / read_ready / read_last  in/in/in/out/in  64/8/1/1/1  readback from controller
- m_axis_tdata / tkeep / tvalid / tready / tlast  out/out/out/in/out  64/8/1/1/1  readback to host
- busy  out  1  high outside IDLE
- status_err  out  3  sticky {timeout, count_mismatch, zero_size}
- words_xfer  out  C_NUMWORDS_WIDTH  words moved in current or last command

Function
REQ-005 States SHALL be IDLE, ISSUE, WRITE, WAIT_DONE, READ.
REQ-006 IDLE: cmd_ready=1; on cmd_valid the block SHALL latch rdwrb and size, clear status_err and words_xfer, and go to ISSUE; if size=0 it SHALL set zero_size and stay in IDLE.
REQ-007 ISSUE: ctrl_valid=1 with the latched fields held stable until ctrl_ready; then go to WRITE (rdwrb=0) or READ (rdwrb=1).
REQ-008 WRITE: each 64-bit beat SHALL yield word tdata[31:0] first, then tdata[63:32] only if tkeep[7:4]=4'hF; write_data is the selected word unswapped.
REQ-009 s_axis_tready SHALL pulse only when the last word of the current beat is accepted (write_valid and write_ready).
REQ-010 write_last SHALL assert exactly on word number size; on that handshake the block SHALL go to WAIT_DONE and consume the beat even if its upper word is unused (dropped).
REQ-011 WAIT_DONE: on done the block SHALL return to IDLE.
REQ-012 READ: read_ready SHALL equal m_axis_tready and m_axis SHALL carry read_* combinationally (zero added latency).
REQ-013 In READ, words_xfer SHALL increase by 1 per accepted beat with read_keep=8'h0F and by 2 for 8'hFF.
REQ-014 The block SHALL leave READ for IDLE only after both done and the read_last handshake have been seen, in either order or in the same cycle.
REQ-015 In READ, if accumulated words_xfer at read_last differs from size, the block SHALL set count_mismatch but still complete normally.
REQ-016 In WRITE, words_xfer SHALL increment per accepted write word.
REQ-017 words_xfer SHALL saturate at all-ones.
REQ-018 A timeout counter SHALL reload on any handshake (ctrl, write, read, done) and decrement otherwise in ISSUE/WRITE/WAIT_DONE/READ.
REQ-019 On reaching zero the block SHALL set timeout, drop all valids, and return to IDLE.
REQ-020 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-021 cmd_valid arriving outside IDLE SHALL be ignored (cmd_ready=0).

Reset
REQ-022 Asserting areset SHALL immediately force IDLE, even mid-transfer.
REQ-023 During reset, cmd_ready, s_axis_tready, ctrl_valid, write_valid, write_last, read_ready and m_axis_tvalid SHALL be 0.
REQ-024 During reset, status_err, words_xfer, busy and the timeout counter SHALL be 0.
REQ-025 After deassertion the block SHALL assert cmd_ready on the first clock edge.

Verification
REQ-026 Write size=5, 3 beats with full tkeep -> words lo0,hi0,lo1,hi1,lo2; write_last on 5th word; hi2 dropped; s_axis_tready pulses 3 times; done returns to IDLE; words_xfer=5.
REQ-027 Read size=3, controller returns beats keep FF then 0F with read_last, done two cycles before last -> m_axis mirrors beats; exit only after last; words_xfer=3; status_err=0.
REQ-028 Read size=4 but controller delivers one FF beat with last -> count_mismatch=1, returns to IDLE.
REQ-029 cmd_size=0 -> status_err=3'b001, no ctrl_valid, busy stays 0.
REQ-030 Write with done withheld and C_TIMEOUT_CYCLES=16 -> timeout bit set 16 cycles after last handshake, IDLE.
REQ-031 Assert areset mid-WRITE with write_valid high -> all valids 0 the same cycle; cmd_ready=1 one edge after release.
